ula_operand_stage: RTL and testbench
====================================

# ula_operand_stage

Issue stage directly upstream of the `ULA` block. It accepts decoded instructions, reads two source operands from an internal 32×32 register file, resolves read-after-write hazards with a pending-write scoreboard and a write-back bypass, and presents registered `A`, `B`, `opcode` to the ALU through a valid/ready handshake. ALU results return through the write-back port and update the register file.

## Interface
Parameters:
- `DATA_W`, 32: operand and register width.
- `REG_N`, 32: register count; the address width is log2(REG_N) = 5.
- `OP_W`, 5: ALU opcode width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_opcode`  in  OP_W  ALU operation.
- `in_rd`, `in_rs`, `in_rt`  in  5  destination and source register indices.
- `in_imm`  in  16  immediate operand.
- `in_use_imm`  in  1  when 1, `B` is the sign-extended `in_imm` and `in_rt` is ignored.
- `out_valid`  out  1  `A`/`B`/`opcode`/`out_rd` hold a valid instruction.
- `out_ready`  in  1  ALU side consumes the instruction.
- `A`, `B`  out  DATA_W  registered operands.
- `opcode`  out  OP_W  registered opcode.
- `out_rd`  out  5  destination register, carried alongside the instruction.
- `wb_en`  in  1  write-back strobe.
- `wb_rd`  in  5  write-back register index.
- `wb_data`  in  DATA_W  write-back value (ALU `Out`).
- `busy`  out  1  at least one scoreboard bit is set.

## Operation
- Register r0 always reads 0. Writes to r0 are discarded, and r0 is never marked pending.
- Scoreboard `pending[REG_N-1:0]`:
  - The bit for `rd` is set when an instruction issues with `rd != 0`.
  - The bit for `wb_rd` is cleared when `wb_en` is high.
- A source or destination register is "blocked" when its pending bit is set and it is not being written back this cycle (`wb_en && wb_rd == reg`).
- Hazard: `in_rs` is blocked, or (`!in_use_imm` and `in_rt` is blocked), or `in_rd` is blocked (WAW).
- `in_ready = !hazard && (!out_valid || out_ready)`. This signal is combinational from the `in_*` fields, `pending`, `wb_*` and `out_*`.
- Issue occurs when `in_valid && in_ready`. On issue, the stage captures:
  - `opcode <= in_opcode`
  - `A <= rf[rs]`
  - `B <= in_use_imm ? sext(in_imm) : rf[rt]`
  - `out_rd <= in_rd`
- Operand read bypass: if `wb_en && wb_rd == src && src != 0`, the operand takes `wb_data`, not the stale file value.
- Output state machine:
  - EMPTY → FULL on issue.
  - FULL → EMPTY on `out_ready` with no issue.
  - FULL → FULL on `out_ready` with a simultaneous issue (back-to-back).
  - FULL holds while `out_ready` is low; `A`/`B`/`opcode`/`out_rd` stay stable.
- Simultaneous issue with `rd == X` and write-back of `X`: the set wins, so `pending[X]` stays 1.
- Write-back to a register that is not pending: the register file is written and the scoreboard is unchanged.

## Timing
- Issue latency: one cycle from the accepting edge to `out_valid` high.
- Throughput: one instruction per cycle when `out_ready` is held high and there are no hazards.
- A write-back at edge N is visible through the bypass during cycle N-1 and through the file from cycle N onward.
- Reset (asynchronous, any cycle, including mid-stall): returns all outputs and state to their reset values. In-flight instructions are dropped.
- Reset values:
  - `out_valid`=0; `A`=0; `B`=0; `opcode`=0; `out_rd`=0.
  - `busy`=0; `pending`=0; all registers = 0.
  - `in_ready` follows its equation, so it is 1 after reset.

## Structure
- Shared package `ula_pkg` holds:
  - widths `DATA_W`, `OP_W`, `REG_AW`;
  - the ALU opcode constants: ADD 00000, ADDINC 00001, INCA 00011, SUBDEC 00100, SUB 00101, DECA 00110, LSL 01000, ASR 01001, ZERO 10000, AND 10001, … , ONE 11111;
  - the output state encoding EMPTY/FULL.
- One sub-module, `ula_regfile`:
  - two combinational read ports, one synchronous write port;
  - r0 hardwired to zero;
  - write-through bypass on the read ports.
- The scoreboard, hazard logic and output register live in the top level.

## Test plan
- **Reset then ADD:** after reset, write r1=1 and r2=2 via `wb`, then issue ADD rd=3, rs=1, rt=2. Required: `out_valid` one cycle later with A=1, B=2, opcode=00000, out_rd=3; `pending[3]`=1 and `busy`=1.
- **Immediate sign-extension:** issue SUB rs=1, `in_use_imm`=1, imm=0xFFFF. Required: B=0xFFFFFFFF; rt's pending state is ignored.
- **RAW stall and bypass:**
  - Issue ADD rd=4, then SUB rs=4. Required: `in_ready`=0 until `wb_en` with `wb_rd`=4 and `wb_data`=0x00000005.
  - In that write-back cycle the SUB issues. Required: A=5 via the bypass.
- **Backpressure:** hold `out_ready`=0 with FULL and present a new instruction. Required: `in_ready`=0 and A/B/opcode stable for 5 cycles; raising `out_ready` accepts the new instruction on the same edge.
- **r0 handling:** `wb` to r0 with 0xDEADBEEF, then issue with rs=0. Required: A=0. An issue with rd=0 leaves `busy`=0.
- **Reset mid-operation:** assert `reset` while FULL with `pending`≠0. Required: immediately `out_valid`=0 and `busy`=0; subsequent reads of previously written registers return 0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared widths, ALU opcode encoding and output-state encoding for the
// operand stage feeding the ULA.
package ula_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int REG_N  = 32;
  localparam int REG_AW = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'b00000,
    OP_ADDINC = 5'b00001,
    OP_INCA   = 5'b00011,
    OP_SUBDEC = 5'b00100,
    OP_SUB    = 5'b00101,
    OP_DECA   = 5'b00110,
    OP_LSL    = 5'b01000,
    OP_ASR    = 5'b01001,
    OP_ZERO   = 5'b10000,
    OP_AND    = 5'b10001,
    OP_ONE    = 5'b11111
  } alu_op_e;

  // Output register occupancy.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/ula_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// r0 hardwired to zero, and write-through so a same-cycle write is visible
// on the read ports.
module ula_regfile
  import ula_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int AW     = $clog2(REG_N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [REG_N];
  logic [DATA_W-1:0] mem_d [REG_N];

  // Next register contents: only the addressed non-zero entry changes.
  always_comb begin
    // NOTE: copy the current state first so every path assigns mem_d and no latch is inferred.
    mem_d = mem_q;
    if (wr_en && (wr_addr != '0)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Register storage; every entry is cleared so reads after reset return 0.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: this array is reset on purpose -- software relies on registers reading 0 after reset, so it cannot map to a plain RAM macro.
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      mem_q <= mem_d;
    end
  end

  // Read port A: r0 is zero, a same-cycle write is forwarded.
  always_comb begin
    rd_data_a = mem_q[rd_addr_a];
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rd_data_b = mem_q[rd_addr_b];
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: rtl/ula_operand_stage.sv
// Issue stage ahead of the ULA: reads operands, tracks outstanding writes in
// a pending scoreboard, stalls on RAW/WAW hazards and holds one instruction
// in an output register behind a valid/ready handshake.
module ula_operand_stage
  import ula_pkg::*;
#(
  parameter int DATA_W = ula_pkg::DATA_W,
  parameter int REG_N  = ula_pkg::REG_N,
  parameter int OP_W   = ula_pkg::OP_W,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [AW-1:0]     in_rd,
  input  logic [AW-1:0]     in_rs,
  input  logic [AW-1:0]     in_rt,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   opcode,
  output logic [AW-1:0]     out_rd,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  logic [REG_N-1:0]  pending_q, pending_d;
  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [AW-1:0]     out_rd_q, out_rd_d;

  logic [DATA_W-1:0] rs_data, rt_data, imm_sext;
  logic              hazard, issue;

  // A register blocks issue while a write to it is outstanding, unless that
  // write is landing this cycle (the bypass then supplies the value).
  function automatic logic is_blocked(input logic [AW-1:0]    r,
                                      input logic [REG_N-1:0] pend,
                                      input logic             wen,
                                      input logic [AW-1:0]    wr);
    return pend[r] && !(wen && (wr == r));
  endfunction

  ula_regfile #(
    .DATA_W(DATA_W),
    .REG_N (REG_N)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .rd_addr_a(in_rs),
    .rd_data_a(rs_data),
    .rd_addr_b(in_rt),
    .rd_data_b(rt_data),
    .wr_en    (wb_en),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  assign imm_sext  = {{(DATA_W-16){in_imm[15]}}, in_imm};
  assign out_valid = (state_q == ST_FULL);
  assign busy      = |pending_q;
  assign A         = a_q;
  assign B         = b_q;
  assign opcode    = opcode_q;
  assign out_rd    = out_rd_q;

  // Hazard detection and handshake: rt only matters when B comes from the file.
  always_comb begin
    hazard = is_blocked(in_rs, pending_q, wb_en, wb_rd)
          || (!in_use_imm && is_blocked(in_rt, pending_q, wb_en, wb_rd))
          || is_blocked(in_rd, pending_q, wb_en, wb_rd);
    in_ready = !hazard && (!out_valid || out_ready);
    issue    = in_valid && in_ready;
  end

  // Scoreboard update: clear on write-back, then set on issue so a
  // simultaneous issue to the same register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (issue && (in_rd != '0)) begin
      pending_d[in_rd] = 1'b1;
    end
  end

  // Output register occupancy and captured instruction fields.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    opcode_d = opcode_q;
    out_rd_d = out_rd_q;
    case (state_q)
      ST_EMPTY: if (issue) state_d = ST_FULL;
      default:  if (out_ready && !issue) state_d = ST_EMPTY;
    endcase
    if (issue) begin
      a_d      = rs_data;
      b_d      = in_use_imm ? imm_sext : rt_data;
      opcode_d = in_opcode;
      out_rd_d = in_rd;
    end
  end

  // Stage state; reset drops any in-flight instruction and all pending bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      state_q   <= ST_EMPTY;
      a_q       <= '0;
      b_q       <= '0;
      opcode_q  <= '0;
      out_rd_q  <= '0;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opcode_q  <= opcode_d;
      out_rd_q  <= out_rd_d;
    end
  end

endmodule

// File: tb/tb_ula_operand_stage.sv
// Self-checking bench for ula_operand_stage: a reference model of the
// register file and scoreboard predicts in_ready, and a queue of expected
// output records is compared whenever the output register holds data.
module tb_ula_operand_stage;
  import ula_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs = '0, in_rt = '0;
  logic [15:0] in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] A, B;
  logic [4:0]  opcode;
  logic [4:0]  out_rd;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rd, rs, rt;
    logic [15:0] imm;
    logic        use_imm;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] m_rf [32];
  logic [31:0] m_pending = '0;
  vec_t        vecs [6];

  ula_operand_stage dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_imm    (in_imm),
    .in_use_imm(in_use_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic m_blocked(input logic [4:0] r);
    return m_pending[r] && !(wb_en && wb_rd == r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pending = '0;
    sb.delete();
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [15:0] imm, input logic ui);
    in_valid = v; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm = imm; in_use_imm = ui;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_en = en; wb_rd = rd; wb_data = data;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
    set_wb(1'b0, '0, '0);
  endtask

  // One clock: predict ready, push/pop the scoreboard, advance the model,
  // then compare the registered outputs against the scoreboard head.
  task automatic tick();
    logic hz, rdy;
    exp_t e;
    #1;
    hz  = m_blocked(in_rs) || (!in_use_imm && m_blocked(in_rt)) || m_blocked(in_rd);
    rdy = !hz && (sb.size() == 0 || out_ready);
    check("in_ready", in_ready, rdy);
    check("busy", busy, |m_pending);
    if (sb.size() != 0 && out_ready) void'(sb.pop_front());
    if (in_valid && rdy) begin
      e.a  = m_read(in_rs);
      e.b  = in_use_imm ? {{16{in_imm[15]}}, in_imm} : m_read(in_rt);
      e.op = in_opcode;
      e.rd = in_rd;
      sb.push_back(e);
    end
    if (wb_en) begin
      if (wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
      m_pending[wb_rd] = 1'b0;
    end
    if (in_valid && rdy && in_rd != 5'd0) m_pending[in_rd] = 1'b1;
    @(posedge clock);
    #1;
    check("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("sb_A", A, sb[0].a);
      check("sb_B", B, sb[0].b);
      check("sb_opcode", opcode, sb[0].op);
      check("sb_out_rd", out_rd, sb[0].rd);
    end
  endtask

  initial begin
    model_reset();
    vecs[0] = '{OP_ADD, 5'd20, 5'd10, 5'd11, 16'h0000, 1'b0, 32'h0000_000A, 32'h1234_5678};
    vecs[1] = '{OP_SUB, 5'd21, 5'd12, 5'd13, 16'h0000, 1'b0, 32'hFFFF_0000, 32'h8000_0001};
    vecs[2] = '{OP_LSL, 5'd22, 5'd13, 5'd0,  16'h0004, 1'b1, 32'h8000_0001, 32'h0000_0004};
    vecs[3] = '{OP_ASR, 5'd23, 5'd11, 5'd12, 16'h8000, 1'b1, 32'h1234_5678, 32'hFFFF_8000};
    vecs[4] = '{OP_AND, 5'd24, 5'd0,  5'd12, 16'h0000, 1'b0, 32'h0000_0000, 32'hFFFF_0000};
    vecs[5] = '{OP_ONE, 5'd25, 5'd13, 5'd10, 16'h0000, 1'b0, 32'h8000_0001, 32'h0000_000A};

    // Reset values.
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_opcode", opcode, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #1;

    // Reset then ADD.
    idle(); set_wb(1'b1, 5'd1, 32'd1); tick();
    set_wb(1'b1, 5'd2, 32'd2); tick();
    set_wb(1'b0, '0, '0);
    drive(1'b1, OP_ADD, 5'd3, 5'd1, 5'd2, 16'h0, 1'b0); tick();
    check("add_A", A, 32'd1);
    check("add_B", B, 32'd2);
    check("add_opcode", opcode, 5'b00000);
    check("add_out_rd", out_rd, 5'd3);
    check("add_busy", busy, 1);

    // Immediate sign extension; rt=3 is pending but ignored.
    idle(); tick();
    drive(1'b1, OP_SUB, 5'd0, 5'd1, 5'd3, 16'hFFFF, 1'b1);
    #1 check("imm_ready", in_ready, 1);
    tick();
    check("imm_B", B, 32'hFFFF_FFFF);
    check("imm_A", A, 32'd1);
    idle(); set_wb(1'b1, 5'd3, 32'h33); tick();

    // RAW stall resolved by the write-back bypass.
    idle(); drive(1'b1, OP_ADD, 5'd4, 5'd1, 5'd2, 16'h0, 1'b0); tick();
    drive(1'b1, OP_SUB, 5'd6, 5'd4, 5'd2, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("raw_stall_ready", in_ready, 0);
      tick();
    end
    set_wb(1'b1, 5'd4, 32'h0000_0005);
    #1 check("raw_wb_ready", in_ready, 1);
    tick();
    check("raw_bypass_A", A, 32'd5);
    check("raw_B", B, 32'd2);

    // Backpressure: FULL with out_ready low holds everything stable.
    idle(); drive(1'b1, OP_ADD, 5'd7, 5'd1, 5'd2, 16'h0, 1'b0); tick();
    out_ready = 1'b0;
    drive(1'b1, OP_SUB, 5'd8, 5'd2, 5'd1, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_ready", in_ready, 0);
      tick();
      check("bp_A", A, 32'd1);
      check("bp_B", B, 32'd2);
      check("bp_opcode", opcode, 5'b00000);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_new_A", A, 32'd2);
    check("bp_new_B", B, 32'd1);
    check("bp_new_opcode", opcode, 5'b00101);
    check("bp_new_out_rd", out_rd, 5'd8);

    // r0 handling.
    idle(); set_wb(1'b1, 5'd0, 32'hDEAD_BEEF); tick();
    set_wb(1'b1, 5'd6, 32'h66); tick();
    set_wb(1'b1, 5'd7, 32'h77); tick();
    set_wb(1'b1, 5'd8, 32'h88); tick();
    idle(); drive(1'b1, OP_AND, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0); tick();
    check("r0_A", A, 32'd0);
    check("r0_busy", busy, 0);

    // Issue and write-back of the same register: pending stays set.
    idle(); drive(1'b1, OP_ADD, 5'd11, 5'd1, 5'd2, 16'h0, 1'b0);
    set_wb(1'b1, 5'd11, 32'h99); tick();
    check("set_wins_busy", busy, 1);

    // Back-to-back vector table (also clears r11 via preload).
    idle(); set_wb(1'b1, 5'd10, 32'h0000_000A); tick();
    set_wb(1'b1, 5'd11, 32'h1234_5678); tick();
    set_wb(1'b1, 5'd12, 32'hFFFF_0000); tick();
    set_wb(1'b1, 5'd13, 32'h8000_0001); tick();
    set_wb(1'b0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].use_imm);
      #1 check("tbl_ready", in_ready, 1);
      tick();
      check("tbl_A", A, vecs[i].exp_a);
      check("tbl_B", B, vecs[i].exp_b);
      check("tbl_opcode", opcode, vecs[i].op);
      check("tbl_out_rd", out_rd, vecs[i].rd);
    end
    idle();
    for (int i = 20; i < 26; i++) begin
      set_wb(1'b1, 5'(i), 32'(i));
      tick();
    end
    idle(); tick();
    check("tbl_busy_clear", busy, 0);

    // Reset mid-operation: FULL and pending set.
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 5'd9, 5'd10, 5'd11, 16'h0, 1'b0); tick();
    idle(); tick();
    check("mid_busy_before", busy, 1);
    check("mid_valid_before", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_A", A, 0);
    check("mid_in_ready", in_ready, 1);
    model_reset();
    @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 5'd3, 5'd10, 5'd11, 16'h0, 1'b0); tick();
    check("post_rst_A", A, 32'd0);
    check("post_rst_B", B, 32'd0);
    idle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
